// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding and hazard detection for the EX stage, with a busy scoreboard for the
// long-latency unit. Define FWD_STATS_EN to build the saturating stall counter.
module fwd_hazard_scoreboard #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 2),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ex_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]    ex_rs_addr,
    input  logic [NUM_SRC-1:0]           ex_rs_used,
    input  logic [NUM_STAGES*ADDR_W-1:0] stg_rd_addr,
    input  logic [NUM_STAGES-1:0]        stg_reg_write,
    input  logic [NUM_STAGES-1:0]        stg_data_ready,
    input  logic                         lop_issue,
    input  logic [ADDR_W-1:0]            lop_rd_addr,
    input  logic                         lop_done,
    input  logic [ADDR_W-1:0]            lop_done_rd,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
    output logic                         stall,
    output logic [2**ADDR_W-1:0]         busy_vec,
    output logic [CNT_W-1:0]             stall_count
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [NumRegs-1:0] busy_q, busy_d;
    logic [NUM_SRC-1:0] src_hazard;
    logic               waw_hazard;
    logic               busy_set;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [ADDR_W-1:0] addr;
        logic              found;
        logic              hazard;
        logic [SEL_W-1:0]  sel;

        assign addr = ex_rs_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            sel    = '0;
            hazard = 1'b0;
            found  = 1'b0;
            if (ex_rs_used[i] && (addr != '0)) begin
                // Youngest matching producer owns the value, even when it is not ready yet.
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (!found && stg_reg_write[k] &&
                        (stg_rd_addr[k*ADDR_W +: ADDR_W] == addr)) begin
                        found = 1'b1;
                        if (stg_data_ready[k]) begin
                            sel = SEL_W'(k + 1);
                        end else begin
                            hazard = 1'b1;
                        end
                    end
                end
                if (!found && busy_q[addr]) begin
                    if (lop_done && (lop_done_rd == addr)) begin
                        sel = SEL_W'(NUM_STAGES + 1);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end

        assign fwd_sel[i*SEL_W +: SEL_W] = sel;
        assign src_hazard[i]             = hazard;
    end

    // A completing long-op to the same register releases it in time for the new issue.
    assign waw_hazard = lop_issue && (lop_rd_addr != '0) && busy_q[lop_rd_addr] &&
                        !(lop_done && (lop_done_rd == lop_rd_addr));

    assign stall    = ex_valid && ((|src_hazard) || waw_hazard);
    assign busy_set = ex_valid && lop_issue && !stall && (lop_rd_addr != '0);

    always_comb begin
        busy_d = busy_q;
        if (lop_done) begin
            busy_d[lop_done_rd] = 1'b0;
        end
        if (busy_set) begin
            busy_d[lop_rd_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard; a second CNT_W=4 instance exercises counter saturation.
module tb_fwd_hazard_scoreboard;

`ifdef FWD_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [9:0]  ex_rs_addr;
    logic [1:0]  ex_rs_used;
    logic [9:0]  stg_rd_addr;
    logic [1:0]  stg_reg_write;
    logic [1:0]  stg_data_ready;
    logic        lop_issue;
    logic [4:0]  lop_rd_addr;
    logic        lop_done;
    logic [4:0]  lop_done_rd;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] busy_vec;
    logic [15:0] stall_count;
    logic [3:0]  fwd_sel4;
    logic        stall4;
    logic [31:0] busy_vec4;
    logic [3:0]  stall_count4;

    int          checks;
    int          failures;
    logic        exp_stall;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;

    fwd_hazard_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_rs_addr     (ex_rs_addr),
        .ex_rs_used     (ex_rs_used),
        .stg_rd_addr    (stg_rd_addr),
        .stg_reg_write  (stg_reg_write),
        .stg_data_ready (stg_data_ready),
        .lop_issue      (lop_issue),
        .lop_rd_addr    (lop_rd_addr),
        .lop_done       (lop_done),
        .lop_done_rd    (lop_done_rd),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .busy_vec       (busy_vec),
        .stall_count    (stall_count)
    );

    fwd_hazard_scoreboard #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_rs_addr     (ex_rs_addr),
        .ex_rs_used     (ex_rs_used),
        .stg_rd_addr    (stg_rd_addr),
        .stg_reg_write  (stg_reg_write),
        .stg_data_ready (stg_data_ready),
        .lop_issue      (lop_issue),
        .lop_rd_addr    (lop_rd_addr),
        .lop_done       (lop_done),
        .lop_done_rd    (lop_done_rd),
        .fwd_sel        (fwd_sel4),
        .stall          (stall4),
        .busy_vec       (busy_vec4),
        .stall_count    (stall_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model driven by the bench's own expected stall.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt  <= '0;
            exp_cnt4 <= '0;
        end else if (exp_stall) begin
            if (exp_cnt != 16'hFFFF) exp_cnt <= exp_cnt + 16'd1;
            if (exp_cnt4 != 4'hF) exp_cnt4 <= exp_cnt4 + 4'd1;
        end
    end

    task automatic idle();
        ex_valid       = 1'b0;
        ex_rs_addr     = '0;
        ex_rs_used     = '0;
        stg_rd_addr    = '0;
        stg_reg_write  = '0;
        stg_data_ready = '0;
        lop_issue      = 1'b0;
        lop_rd_addr    = '0;
        lop_done       = 1'b0;
        lop_done_rd    = '0;
        exp_stall      = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        checks++;
        if (busy_vec !== 32'h0) begin
            $display("FAIL reset_busy got %h expected %h", busy_vec, 32'h0);
            failures++;
        end
        checks++;
        if (stall_count !== 16'h0) begin
            $display("FAIL reset_count got %0d expected 0", stall_count);
            failures++;
        end
        checks++;
        if (stall !== 1'b0) begin
            $display("FAIL reset_stall got %b expected 0", stall);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle();
        ex_valid       = 1'b1;
        ex_rs_addr     = {5'd6, 5'd5};
        ex_rs_used     = 2'b11;
        stg_rd_addr    = {5'd5, 5'd5};
        stg_reg_write  = 2'b11;
        stg_data_ready = 2'b11;
        #1;
        checks++;
        if (fwd_sel !== 4'b00_01 || stall !== 1'b0) begin
            $display("FAIL b2b_youngest got sel=%b stall=%b expected sel=0001 stall=0",
                     fwd_sel, stall);
            failures++;
        end
        @(negedge clk);
        stg_rd_addr = {5'd5, 5'd6};
        #1;
        checks++;
        if (fwd_sel !== 4'b01_10 || stall !== 1'b0) begin
            $display("FAIL b2b_two_stages got sel=%b stall=%b expected sel=0110 stall=0",
                     fwd_sel, stall);
            failures++;
        end
        @(negedge clk);
        stg_rd_addr    = {5'd5, 5'd5};
        stg_reg_write  = 2'b10;
        stg_data_ready = 2'b10;
        #1;
        checks++;
        if (fwd_sel !== 4'b00_10 || stall !== 1'b0) begin
            $display("FAIL b2b_no_write got sel=%b stall=%b expected sel=0010 stall=0",
                     fwd_sel, stall);
            failures++;
        end
        @(negedge clk);
        stg_reg_write = 2'b11;
        exp_stall     = 1'b1;
        #1;
        checks++;
        if (fwd_sel !== 4'b00_00 || stall !== 1'b1) begin
            $display("FAIL b2b_young_not_ready got sel=%b stall=%b expected sel=0000 stall=1",
                     fwd_sel, stall);
            failures++;
        end
        @(negedge clk);
        ex_valid  = 1'b0;
        exp_stall = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            $display("FAIL b2b_invalid_stall got %b expected 0", stall);
            failures++;
        end
        @(negedge clk);
        stg_data_ready = 2'b11;
        #1;
        checks++;
        if (fwd_sel !== 4'b00_01) begin
            $display("FAIL b2b_invalid_sel got %b expected 0001", fwd_sel);
            failures++;
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        ex_valid      = 1'b1;
        ex_rs_addr    = {5'd7, 5'd0};
        ex_rs_used    = 2'b10;
        stg_rd_addr   = {5'd0, 5'd7};
        stg_reg_write = 2'b01;
        exp_stall     = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            $display("FAIL load_use_stall got %b expected 1", stall);
            failures++;
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            if (stall_count !== (Stats ? exp_cnt : 16'd0)) begin
                $display("FAIL load_use_count got %0d expected %0d", stall_count,
                         Stats ? exp_cnt : 16'd0);
                failures++;
            end
        end
        stg_data_ready = 2'b01;
        exp_stall      = 1'b0;
        #1;
        checks++;
        if (fwd_sel !== 4'b01_00 || stall !== 1'b0) begin
            $display("FAIL load_use_ready got sel=%b stall=%b expected sel=0100 stall=0",
                     fwd_sel, stall);
            failures++;
        end
    endtask

    task automatic test_long_op();
        @(negedge clk);
        idle();
        ex_valid    = 1'b1;
        lop_issue   = 1'b1;
        lop_rd_addr = 5'd9;
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            $display("FAIL lop_busy_set got %h expected %h", busy_vec, 32'h0000_0200);
            failures++;
        end
        idle();
        ex_valid   = 1'b1;
        ex_rs_addr = {5'd0, 5'd9};
        ex_rs_used = 2'b01;
        exp_stall  = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0) begin
            $display("FAIL lop_wait got sel=%b stall=%b expected sel=0000 stall=1", fwd_sel, stall);
            failures++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (stall !== 1'b1 || busy_vec !== 32'h0000_0200) begin
            $display("FAIL lop_hold got stall=%b busy=%h expected stall=1 busy=00000200",
                     stall, busy_vec);
            failures++;
        end
        lop_done    = 1'b1;
        lop_done_rd = 5'd9;
        exp_stall   = 1'b0;
        #1;
        checks++;
        if (fwd_sel !== 4'b00_11 || stall !== 1'b0) begin
            $display("FAIL lop_bypass got sel=%b stall=%b expected sel=0011 stall=0", fwd_sel, stall);
            failures++;
        end
        @(negedge clk);
        idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            $display("FAIL lop_busy_clear got %h expected %h", busy_vec, 32'h0);
            failures++;
        end
    endtask

    task automatic test_waw();
        @(negedge clk);
        idle();
        ex_valid    = 1'b1;
        lop_issue   = 1'b1;
        lop_rd_addr = 5'd4;
        @(negedge clk);
        exp_stall = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            $display("FAIL waw_stall got %b expected 1", stall);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_0010) begin
            $display("FAIL waw_busy_hold got %h expected %h", busy_vec, 32'h0000_0010);
            failures++;
        end
        lop_done    = 1'b1;
        lop_done_rd = 5'd4;
        exp_stall   = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            $display("FAIL waw_release got %b expected 0", stall);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_0010) begin
            $display("FAIL waw_set_wins got %h expected %h", busy_vec, 32'h0000_0010);
            failures++;
        end
        idle();
        lop_done    = 1'b1;
        lop_done_rd = 5'd4;
        @(negedge clk);
        idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            $display("FAIL waw_cleanup got %h expected %h", busy_vec, 32'h0);
            failures++;
        end
    endtask

    task automatic test_x0_unused();
        @(negedge clk);
        idle();
        ex_valid    = 1'b1;
        lop_issue   = 1'b1;
        lop_rd_addr = 5'd12;
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_1000) begin
            $display("FAIL x0_busy12 got %h expected %h", busy_vec, 32'h0000_1000);
            failures++;
        end
        idle();
        ex_valid      = 1'b1;
        ex_rs_addr    = {5'd12, 5'd0};
        ex_rs_used    = 2'b01;
        stg_rd_addr   = {5'd0, 5'd0};
        stg_reg_write = 2'b01;
        lop_issue     = 1'b1;
        lop_rd_addr   = 5'd0;
        #1;
        checks++;
        if (fwd_sel !== 4'b0 || stall !== 1'b0) begin
            $display("FAIL x0_unused got sel=%b stall=%b expected sel=0000 stall=0", fwd_sel, stall);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_1000) begin
            $display("FAIL x0_issue got %h expected %h", busy_vec, 32'h0000_1000);
            failures++;
        end
        idle();
        lop_done    = 1'b1;
        lop_done_rd = 5'd3;
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_1000) begin
            $display("FAIL done_not_busy got %h expected %h", busy_vec, 32'h0000_1000);
            failures++;
        end
        lop_done_rd = 5'd12;
        @(negedge clk);
        idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            $display("FAIL x0_cleanup got %h expected %h", busy_vec, 32'h0);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        ex_valid    = 1'b1;
        lop_issue   = 1'b1;
        lop_rd_addr = 5'd9;
        @(negedge clk);
        idle();
        ex_valid      = 1'b1;
        ex_rs_addr    = {5'd0, 5'd7};
        ex_rs_used    = 2'b01;
        stg_rd_addr   = {5'd0, 5'd7};
        stg_reg_write = 2'b01;
        exp_stall     = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (stall_count !== (Stats ? exp_cnt : 16'd0)) begin
            $display("FAIL stall_count_accum got %0d expected %0d", stall_count,
                     Stats ? exp_cnt : 16'd0);
            failures++;
        end
        checks++;
        if (stall_count4 !== (Stats ? exp_cnt4 : 4'd0)) begin
            $display("FAIL stall_count_saturate got %0d expected %0d", stall_count4,
                     Stats ? exp_cnt4 : 4'd0);
            failures++;
        end
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            $display("FAIL pre_reset_busy got %h expected %h", busy_vec, 32'h0000_0200);
            failures++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || stall_count !== 16'h0 || stall_count4 !== 4'h0) begin
            $display("FAIL async_reset got busy=%h cnt=%0d cnt4=%0d expected all 0",
                     busy_vec, stall_count, stall_count4);
            failures++;
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_long_op();
        test_waw();
        test_x0_unused();
        test_reset_mid();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
